// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock-enable divider.
// The master side drives enables, ratios and strobes; the slave side
// (the divider) returns the divided clocks, ticks and pending flags.
interface clk_div_prog_if #(
    parameter int CNT_W  = 8,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] div_in;
    logic                    div_load;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       div_pending;

    modport master (
        output en, div_in, div_load, sync,
        input  clk_out, tick, div_pending
    );

    modport slave (
        input  en, div_in, div_load, sync,
        output clk_out, tick, div_pending
    );
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock-enable divider.
// Each channel counts 0..D-1, drives a registered near-50% divided clock
// and a one-cycle tick on every rising edge of it. New ratios land in a
// shadow register and only take effect at a period boundary, on sync,
// or while the channel is disabled, so no runt or stretched pulse occurs.

// One divider channel. All outputs come straight from flops.
module clk_div_prog_ch #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 6   // must be >= 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             pending_o
);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [CNT_W-1:0] div_q, div_d;      // active ratio D
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] shadow_eff;
    logic [CNT_W-1:0] div_apply;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_len;
    logic             pend_eff;
    logic             wrap;

    // Next-state: a load on this edge is visible to any apply on this edge,
    // so load+sync and load-on-wrap both take the new ratio immediately.
    always_comb begin
        load_val   = (div_i < TWO) ? TWO : div_i;
        shadow_eff = load_i ? load_val : shadow_q;
        pend_eff   = load_i | pend_q;
        div_apply  = pend_eff ? shadow_eff : div_q;
        wrap       = (cnt_q == div_q - ONE);
        cnt_inc    = cnt_q + ONE;
        high_len   = div_q - (div_q >> 1);

        div_d      = div_q;
        shadow_d   = shadow_eff;
        pend_d     = pend_eff;
        cnt_d      = cnt_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;

        if (!en_i) begin
            // Park one count before wrap so the first enabled edge starts
            // a fresh full period with tick.
            div_d     = div_apply;
            pend_d    = 1'b0;
            cnt_d     = div_apply - ONE;
            clk_out_d = 1'b0;
        end else if (sync_i || wrap) begin
            // Count 0 is always inside the high phase (H >= 1 for D >= 2),
            // so the new period's first output is high whatever D becomes.
            div_d     = div_apply;
            pend_d    = 1'b0;
            cnt_d     = '0;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
        end else begin
            cnt_d     = cnt_inc;
            clk_out_d = (cnt_inc < high_len);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= DEF;
            shadow_q  <= DEF;
            cnt_q     <= DEF - ONE;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign pending_o = pend_q;
endmodule

// Top: one channel instance per lane, sharing the load and sync strobes.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int NUM_CH      = 2,
    parameter int DEFAULT_DIV = 6
) (
    input  logic           clk,
    input  logic           reset,
    clk_div_prog_if.slave  bus
);
    logic [NUM_CH-1:0][CNT_W-1:0] div_in_w;
    logic [NUM_CH-1:0]            clk_out_w;
    logic [NUM_CH-1:0]            tick_w;
    logic [NUM_CH-1:0]            pend_w;

    assign div_in_w = bus.div_in;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        clk_div_prog_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en_i      (bus.en[ch]),
            .sync_i    (bus.sync),
            .load_i    (bus.div_load),
            .div_i     (div_in_w[ch]),
            .clk_out_o (clk_out_w[ch]),
            .tick_o    (tick_w[ch]),
            .pending_o (pend_w[ch])
        );
    end

    assign bus.clk_out     = clk_out_w;
    assign bus.tick        = tick_w;
    assign bus.div_pending = pend_w;
endmodule
